// File: rtl/dsp_mac_sequencer.sv
// Operand sequencer for a DSP48A1 slice: streams N_TERMS beats through the
// multiplier, accumulates via P feedback, and hands out one result per frame.
module dsp_mac_sequencer #(
    parameter int N_TERMS = 8,
    parameter int LAT     = 4
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_a,
    input  logic [17:0] in_b,
    input  logic [17:0] in_d,
    input  logic        in_preadd,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [17:0] dsp_d,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    output logic        dsp_cep,
    output logic        dsp_rstp,
    input  logic [47:0] dsp_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_data,
    output logic        busy
);

    localparam int CW = $clog2(LAT);
    localparam int TW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WIN,
        NEXT,
        CAPT,
        OUT
    } state_t;

    state_t state, state_n;

    logic [CW-1:0] cnt;
    logic [TW-1:0] term_idx;
    logic [17:0]   a_q, b_q, d_q;
    logic          pre_q;
    logic [47:0]   res_q;
    logic          ce_q, rstp_q;
    logic          accept, last_cnt, last_term;

    assign accept    = in_valid && in_ready;
    assign last_cnt  = (cnt == CW'(LAT - 1));
    assign last_term = (term_idx == TW'(N_TERMS - 1));

    always_ff @(posedge clk) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dsp_cep   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = WIN;
            end
            WIN: begin
                if (last_cnt) begin
                    dsp_cep = 1'b1;
                    state_n = last_term ? CAPT : NEXT;
                end
            end
            NEXT: begin
                in_ready = 1'b1;
                if (in_valid) state_n = WIN;
            end
            CAPT: state_n = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            cnt      <= '0;
            term_idx <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            pre_q    <= 1'b0;
            res_q    <= '0;
            ce_q     <= 1'b0;
            rstp_q   <= 1'b1;
        end else begin
            ce_q   <= 1'b1;
            rstp_q <= 1'b0;
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                d_q   <= in_d;
                pre_q <= in_preadd;
                cnt   <= '0;
                // first beat of a frame restarts the term index
                term_idx <= (state == IDLE) ? '0 : term_idx + TW'(1);
            end else if (state == WIN && !last_cnt) begin
                cnt <= cnt + CW'(1);
            end
            if (state == CAPT) res_q <= dsp_p;
        end
    end

    // Z mux selects zero on the first term, P feedback afterwards
    assign dsp_opmode = ce_q
        ? {3'b000, pre_q, (term_idx == '0) ? 2'b00 : 2'b10, 2'b01}
        : 8'h00;

    assign dsp_a    = a_q;
    assign dsp_b    = b_q;
    assign dsp_d    = d_q;
    assign dsp_ce   = ce_q;
    assign dsp_rstp = rstp_q;
    assign out_data = res_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural slice, frame-level reference sums,
// scoreboard queue popped by an independent output monitor.
module tb_dsp_mac_sequencer;

    localparam int N = 4;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_a = '0, in_b = '0, in_d = '0;
    logic        in_preadd = 1'b0;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce, dsp_cep, dsp_rstp;
    logic [47:0] dsp_p;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [47:0] out_data;
    logic        busy;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.N_TERMS(N), .LAT(L)) dut (
        .clk(clk), .RSTN(RSTN),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_preadd(in_preadd),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d),
        .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_cep(dsp_cep),
        .dsp_rstp(dsp_rstp), .dsp_p(dsp_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    // Slice: A1/B1(pre-add)/OPMODE regs -> MREG -> PREG
    logic [17:0] s_a, s_b;
    logic [7:0]  s_op;
    logic [35:0] s_m;
    logic [47:0] s_p;

    always @(posedge clk) begin
        if (dsp_rstp) begin
            s_a <= '0; s_b <= '0; s_op <= '0; s_m <= '0; s_p <= '0;
        end else begin
            if (dsp_ce) begin
                s_a  <= dsp_a;
                s_b  <= dsp_opmode[4] ? 18'(dsp_d + dsp_b) : dsp_b;
                s_op <= dsp_opmode;
                s_m  <= 36'(s_a) * 36'(s_b);
            end
            if (dsp_cep)
                s_p <= ((s_op[3:2] == 2'b10) ? s_p : 48'd0) + 48'(s_m);
        end
    end
    assign dsp_p = s_p;

    int tests = 0, fails = 0;
    int cyc = 0, cyc0 = 0, rise_cyc = 0, hi_run = 0, last_len = 0;
    int cep_cnt = 0, cep_base = 0, rdy_mode = 0;
    logic [17:0] fa[N], fb[N], fd[N];
    logic        fp[N];
    logic [47:0] sbq[$];
    logic [47:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [47:0] model();
        longint acc = 0;
        for (int i = 0; i < N; i++) begin
            longint op = fp[i] ? ((longint'(fd[i]) + longint'(fb[i])) % 262144)
                               : longint'(fb[i]);
            acc += longint'(fa[i]) * op;
        end
        return acc[47:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!RSTN) begin
                cep_base = cep_cnt;
                hi_run = 0;
            end else begin
                if (dsp_cep) cep_cnt++;
                if (out_valid) begin
                    if (hi_run == 0) rise_cyc = cyc;
                    hi_run++;
                end else if (hi_run > 0) begin
                    last_len = hi_run;
                    hi_run = 0;
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        mon_exp = sbq.pop_front();
                        chk("result", out_data, mon_exp);
                    end
                    chk("cep_per_frame", cep_cnt - cep_base, N);
                    cep_base = cep_cnt;
                end
            end
        end
    end

    task automatic send_beat(input int i);
        int t = 0;
        in_a = fa[i]; in_b = fb[i]; in_d = fd[i]; in_preadd = fp[i];
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (i == 0) cyc0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        chk("opmode", dsp_opmode,
            {3'b000, fp[i], (i == 0) ? 2'b00 : 2'b10, 2'b01});
        chk("win_in_ready", in_ready, 0);
        chk("win_busy", busy, 1);
    endtask

    task automatic run_frame(input bit push, input int stall_at,
                             input int stall_len, input int abort_at,
                             input int gap_max);
        if (push) sbq.push_back(model());
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                RSTN = 1'b0;
                repeat (2) @(negedge clk);
                RSTN = 1'b1;
                return;
            end
            send_beat(i);
            if (i == stall_at) begin
                for (int k = 0; k < L - 1 + stall_len; k++) begin
                    @(negedge clk);
                    chk("stall_cep", in_ready & dsp_cep, 0);
                end
            end else if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || busy) && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue", sbq.size(), 0);
    endtask

    task automatic fill(input logic [17:0] a0, input logic [17:0] a1,
                        input logic [17:0] a2, input logic [17:0] a3,
                        input logic [17:0] b, input logic [17:0] d,
                        input logic p);
        fa[0] = a0; fa[1] = a1; fa[2] = a2; fa[3] = a3;
        for (int i = 0; i < N; i++) begin
            fb[i] = b; fd[i] = d; fp[i] = p;
        end
    endtask

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rstp", dsp_rstp, 1);
        chk("rst_ce", dsp_ce, 0);
        chk("rst_cep", dsp_cep, 0);
        chk("rst_opmode", dsp_opmode, 8'h00);
        chk("rst_dsp_a", dsp_a, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_slice_p", dsp_p, 0);
        RSTN = 1'b1;
        repeat (2) @(negedge clk);
        chk("run_ce", dsp_ce, 1);
        chk("run_rstp", dsp_rstp, 0);

        // plain MAC, continuous valid
        fill(1, 2, 3, 4, 10, 0, 1'b0);
        run_frame(1, -1, 0, -1, 0);
        drain();
        repeat (2) @(negedge clk);
        #2;
        chk("latency", rise_cyc - cyc0, (L + 1) * N + 1);
        chk("valid_pulse_len", last_len, 1);

        // pre-adder
        fill(3, 3, 3, 3, 5, 7, 1'b1);
        run_frame(1, -1, 0, -1, 0);
        drain();

        // stall after beat 2, then output backpressure
        rdy_mode = 2;
        repeat (2) @(negedge clk);
        fill(1, 2, 3, 4, 10, 0, 1'b0);
        run_frame(1, 2, 6, -1, 0);
        t = 0;
        while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #2;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 100);
            chk("bp_in_ready", in_ready, 0);
        end
        rdy_mode = 0;
        t = 0;
        while (!out_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_at_release", out_valid, 1);
        @(negedge clk);
        #2;
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_in_ready", in_ready, 1);
        drain();

        // reset mid-frame, then a clean frame
        fill(9, 9, 9, 9, 9, 0, 1'b0);
        run_frame(0, -1, 0, 3, 0);
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        fill(2, 2, 2, 2, 2, 0, 1'b0);
        run_frame(1, -1, 0, -1, 0);
        drain();

        // pre-adder wrap
        fill(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 1, 18'h3FFFF, 1'b1);
        run_frame(1, -1, 0, -1, 0);
        drain();

        // random frames with gaps and random out_ready
        rdy_mode = 1;
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < N; i++) begin
                fa[i] = 18'($urandom);
                fb[i] = 18'($urandom);
                fd[i] = 18'($urandom);
                fp[i] = 1'($urandom);
            end
            run_frame(1, -1, 0, -1, 3);
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Upstream operand sequencer for the DSP48A1 slice. It accepts a stream of operand beats over a valid/ready handshake and drives the slice's A/B/D/opmode/clock-enable ports. It runs a multiply-accumulate over `N_TERMS` beats per frame, using the slice's P feedback path. It then captures P and presents one 48-bit result per frame on a valid/ready output.

## Interface
Parameters:
- `N_TERMS`, 8 — beats per frame (≥1).
- `LAT`, 4 — cycles each beat is held on the slice (≥3; covers DREG/A1REG/B1REG → MREG → PREG).

Ports:
- `clk` in 1 — single clock; all logic on rising edge.
- `RSTN` in 1 — synchronous, active-low reset.
- `in_valid` in 1, `in_ready` out 1 — operand handshake; a beat transfers on a cycle with both high.
- `in_a`, `in_b`, `in_d` in 18 — operands.
- `in_preadd` in 1 — 1: product = A·(D+B); 0: product = A·B.
- `dsp_a`, `dsp_b`, `dsp_d` out 18 — drive slice A/B/D.
- `dsp_opmode` out 8 — drives slice opmode.
- `dsp_ce` out 1 — drives CEA/CEB/CED/CEM/CEOPMODE.
- `dsp_cep` out 1 — drives CEP.
- `dsp_rstp` out 1 — drives all slice RST* inputs (active-high).
- `dsp_p` in 48 — slice P.
- `out_valid` out 1, `out_ready` in 1 — result handshake.
- `out_data` out 48 — frame result.
- `busy` out 1 — high in any state other than IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1. An accepted beat loads the operand regs, sets `term_idx`=0 and `cnt`=0, and moves to WIN.
  - WIN: `in_ready`=0. `cnt` counts 0..LAT-1. `dsp_cep`=1 only at `cnt`=LAT-1. At `cnt`=LAT-1 the next state is CAPT if `term_idx`=N_TERMS-1, otherwise NEXT.
  - NEXT: `in_ready`=1. An accepted beat loads the operand regs, increments `term_idx`, clears `cnt`, and moves to WIN. Without a beat the FSM waits indefinitely with `dsp_cep`=0.
  - CAPT: registers `out_data`←`dsp_p`, then moves to OUT.
  - OUT: `out_valid`=1 and `in_ready`=0. On `out_ready`=1 it moves to IDLE.
- Operand regs hold their values until the next accepted beat. `dsp_a`/`dsp_b`/`dsp_d` are driven directly from these regs.
- `dsp_opmode` = {3'b000, preadd_reg, Z, 2'b01}, with X=M:
  - Z=2'b00 for `term_idx`=0, which clears the accumulation.
  - Z=2'b10 (P feedback) otherwise.
  - Carry-in, post-subtract and C path are unused (bits 7:5 = 0).
- `dsp_ce`=1 in all states except while in reset.
- P changes only on the `dsp_cep` pulse, so each beat is accumulated exactly once regardless of stalls.
- Arithmetic:
  - Unsigned.
  - The pre-adder D+B is modulo 2^18.
  - The product is 36 bits.
  - The accumulation wraps modulo 2^48; no overflow flag.
- `dsp_rstp` = ~RSTN, registered, so the slice clears in the same reset cycles.

## Timing
- Reset (RSTN=0 at an edge):
  - State IDLE.
  - `in_ready`=1, `out_valid`=0, `busy`=0, `dsp_cep`=0, `dsp_ce`=0, `dsp_rstp`=1.
  - `dsp_opmode`=8'h00, `dsp_a`/`dsp_b`/`dsp_d`=0, `out_data`=0, `cnt`/`term_idx`=0.
- Reset mid-frame or during OUT abandons the frame; no partial result is emitted.
- Each beat occupies 1 accept cycle plus LAT WIN cycles. With `in_valid` held high, beats are accepted every LAT+1 cycles.
- Latency: first accept at cycle 0 → last `dsp_cep` at cycle (LAT+1)·N_TERMS−1 → CAPT → `out_valid` first high at cycle (LAT+1)·N_TERMS+1.
- `out_data` and `out_valid` are stable while `out_ready`=0.
- The next frame's first beat is accepted no earlier than the cycle after the OUT handshake.
- `in_valid` in WIN, CAPT or OUT is ignored, with no transfer.

## Test plan
All scenarios use N_TERMS=4, LAT=4, with the bench connected to a DSP48A1 instance (PREG=MREG=1, DREG=A1REG=B1REG=1, A0REG=B0REG=0, CARRYINSEL "OPMODE5").
- Reset: hold RSTN=0 for 2 cycles → `in_ready`=1, `out_valid`=0, `dsp_rstp`=1, `dsp_opmode`=8'h00, `dsp_cep`=0, and slice P=0.
- Plain MAC: preadd=0, a=1,2,3,4, b=10 each, `in_valid` continuous, `out_ready`=1 → `out_data`=100. `out_valid` rises at cycle 21 after the first accept and stays high exactly 1 cycle.
- Pre-adder: preadd=1, a=3, b=5, d=7 on all 4 beats → `out_data`=144. `dsp_opmode`=8'h11 on beat 0 and 8'h19 on beats 1–3.
- Stall and backpressure:
  - Drop `in_valid` for 6 cycles after beat 2 of the plain-MAC frame → `dsp_cep` stays 0 in NEXT and the result is still 100.
  - Then hold `out_ready`=0 for 10 cycles → `out_valid`=1, `out_data`=100 and `in_ready`=0 throughout. IDLE is reached the cycle after `out_ready`=1.
- Reset mid-frame: assert RSTN=0 after beat 2, then run a fresh frame with a=2, b=2 ×4 → `out_data`=16, with no leftover accumulation.
- Wrap: preadd=1, a=3FFFF, d=3FFFF, b=1 (D+B wraps to 0) ×4 → `out_data`=0.
